// File: rtl/cmp_pipe.sv
// Pipelined compare stage: one operand register (S1) feeding a small circular FIFO of
// {err, result} entries, with a saturating count of true results consumed downstream.
module cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic             out_err,
    output logic [CNT_W-1:0] true_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Returns {err, result}; opcodes 110/111 are illegal and yield a zero result.
    function automatic logic [1:0] cmp_eval(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [2:0]       op);
        logic       lt_s;
        logic       ltu_s;
        logic       eq_s;
        logic [1:0] r_s;
        lt_s  = ($signed(a) < $signed(b));
        ltu_s = (a < b);
        eq_s  = (a == b);
        case (op)
            3'b000:  r_s = {1'b0, lt_s};
            3'b001:  r_s = {1'b0, ltu_s};
            3'b010:  r_s = {1'b0, eq_s};
            3'b011:  r_s = {1'b0, ~eq_s};
            3'b100:  r_s = {1'b0, ~lt_s};
            3'b101:  r_s = {1'b0, ~ltu_s};
            default: r_s = {1'b1, 1'b0};
        endcase
        return r_s;
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;

    logic             res_mem_r [DEPTH];
    logic             err_mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             accept_s;
    logic [1:0]       cmp_s;

    // Handshake and FIFO status decode; in_ready may follow out_ready combinationally.
    always_comb begin
        empty_s  = (wr_ptr_r == rd_ptr_r);
        full_s   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
        pop_s    = (!empty_s) && out_ready;
        push_s   = s1_valid_r && ((!full_s) || pop_s);
        in_ready = (!s1_valid_r) || push_s;
        accept_s = in_valid && in_ready;
        cmp_s    = cmp_eval(s1_a_r, s1_b_r, s1_op_r);
    end

    // S1 operand register: loads on accept, empties when its result moves into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 3'b000;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= in_a;
            s1_b_r     <= in_b;
            s1_op_r    <= in_op;
        end else if (push_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Circular result FIFO; the extra pointer MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_mem_r[i] <= 1'b0;
                err_mem_r[i] <= 1'b0;
            end
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                res_mem_r[wr_ptr_r[AW-1:0]] <= cmp_s[0];
                err_mem_r[wr_ptr_r[AW-1:0]] <= cmp_s[1];
                wr_ptr_r                    <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Saturating count of true results handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (pop_s && res_mem_r[rd_ptr_r[AW-1:0]] && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign out_valid  = !empty_s;
    assign out_result = res_mem_r[rd_ptr_r[AW-1:0]];
    assign out_err    = err_mem_r[rd_ptr_r[AW-1:0]];
    assign true_count = count_r;

endmodule
